wb_bypass_source: RTL and testbench

- Writeback-stage producer of the bypass bus (wb_addr / wb_data / is_wb) consumed by EX-stage forwarding.
- Holds the EX→WB pipeline register and selects the writeback value (ALU, load, PC+4).
- Aligns and extends load data and waits on data-memory return through a small FSM with timeout.
- Generates the load-use stall toward IF/ID/EX.

---
 rtl/wb_bypass_source_pkg.sv | 37 +++
 rtl/wb_bypass_source_load_extend.sv | 44 ++++
 rtl/wb_bypass_source.sv | 235 +++++++++++++++++++++++
 tb/tb_wb_bypass_source.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bypass_source_pkg.sv
// -----------------------------------------------------------------------------
// wb_bypass_source_pkg
//
// Shared encodings for the writeback stage:
//   - wb_sel values choosing the writeback source (ALU / load / PC+4)
//   - funct3 load size/sign encodings
//   - writeback load FSM state type
//   - helper to size the load-wait counter (never narrower than 4 bits)
// -----------------------------------------------------------------------------
package wb_bypass_source_pkg;

  // Writeback source select
  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Load-wait FSM: RUN retires normally, WAIT holds WB for a late load
  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

  // Width of the wait counter: enough to hold the timeout, minimum 4 bits
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/wb_bypass_source_load_extend.sv
// -----------------------------------------------------------------------------
// wb_bypass_source_load_extend
//
// Purely combinational load aligner/extender. Picks the addressed byte or
// halfword out of a word-aligned memory return and sign- or zero-extends it.
//
// Ports:
//   funct3   in   3     load size/sign (LB/LH/LW/LBU/LHU)
//   addr_lo  in   2     low address bits selecting the lane
//   rdata    in   XLEN  word-aligned data from memory
//   ext_data out  XLEN  aligned, extended load result
//
// Misaligned halfword/word accesses are not detected; the lane is simply
// taken from addr_lo[1] (halfword) or ignored (word).
// -----------------------------------------------------------------------------
module wb_bypass_source_load_extend
  import wb_bypass_source_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension; anything that is not a narrow load passes
  // the word through unchanged (covers LW).
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   ext_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   ext_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  ext_data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  ext_data = {{(XLEN-16){1'b0}}, half_sel};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_bypass_source.sv
// -----------------------------------------------------------------------------
// wb_bypass_source
//
// Writeback stage of the core. Holds the EX->WB pipeline register, chooses
// the writeback value (ALU / aligned load / PC+4), and publishes it on the
// bypass bus (wb_addr / wb_data / is_wb) used by EX forwarding and the
// register file. Loads whose data is late park the stage in a WAIT state and
// freeze everything upstream (wb_stall); if data never arrives within
// MEM_TIMEOUT wait cycles the load is dropped with a one-cycle load_fault.
// Also raises the load-use bubble request (lu_stall) toward IF/ID/EX.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_valid/ex_rd/ex_reg_we   instruction leaving EX and its destination
//   ex_wb_sel                  writeback source select
//   ex_alu_result              ALU result, also the load address
//   ex_pc, ex_funct3           PC and load size/sign of the EX instruction
//   flush                      squash the instruction entering WB
//   id_rs1/id_rs2/id_use_*     ID-stage sources for load-use detection
//   dmem_rdata, dmem_rvalid    data-memory load return
//   wb_addr, wb_data, is_wb    bypass / register-file write port
//   wb_stall                   freeze all upstream stages
//   lu_stall                   load-use bubble request
//   load_fault                 one-cycle pulse on load timeout
//   is_wb_load                 (only without WB_LOAD_BYPASS_EN) marks that the
//                              current write is a load result, not bypassable
//
// Build option WB_LOAD_BYPASS_EN: when defined, retiring loads are bypassable
// in their retire cycle (one-cycle load-use penalty) and is_wb_load does not
// exist. When undefined, consumers must use is_wb && !is_wb_load for bypass,
// and lu_stall also covers a load sitting in WB (two-cycle penalty).
// -----------------------------------------------------------------------------
module wb_bypass_source
  import wb_bypass_source_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RA_W        = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_reg_we,
  input  logic [1:0]      ex_wb_sel,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [2:0]      ex_funct3,
  input  logic            flush,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_rvalid,
  output logic [RA_W-1:0] wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            is_wb,
  output logic            wb_stall,
  output logic            lu_stall,
  output logic            load_fault
`ifndef WB_LOAD_BYPASS_EN
  ,
  output logic            is_wb_load
`endif
);

  localparam int              CNT_W   = cnt_width(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  // EX->WB pipeline register
  logic            wb_valid_q, wb_valid_d;
  logic [RA_W-1:0] wb_rd_q, wb_rd_d;
  logic            wb_reg_we_q, wb_reg_we_d;
  logic [1:0]      wb_sel_q, wb_sel_d;
  logic [XLEN-1:0] wb_alu_q, wb_alu_d;
  logic [XLEN-1:0] wb_pc_q, wb_pc_d;
  logic [2:0]      wb_funct3_q, wb_funct3_d;

  // Load-wait FSM
  wb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            wb_we;
  logic            wb_is_load;
  logic            load_retire;
  logic            ex_hit;
  logic [XLEN-1:0] load_data;

  wb_bypass_source_load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .funct3   (wb_funct3_q),
    .addr_lo  (wb_alu_q[1:0]),
    .rdata    (dmem_rdata),
    .ext_data (load_data)
  );

  // Qualifiers of the instruction currently in WB; writes to x0 are dropped
  always_comb begin
    wb_we      = wb_valid_q && wb_reg_we_q && (wb_rd_q != '0);
    wb_is_load = wb_valid_q && (wb_sel_q == WB_SEL_MEM);
  end

  // Load-wait FSM next state and stall/fault decode. A load with data in hand
  // retires in the same cycle; otherwise the stage freezes and counts wait
  // cycles. Data arriving on the timeout cycle still wins over the fault.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wb_stall    = 1'b0;
    load_fault  = 1'b0;
    load_retire = 1'b0;
    case (state_q)
      RUN: begin
        if (wb_is_load) begin
          if (dmem_rvalid) begin
            load_retire = 1'b1;
          end else begin
            wb_stall = 1'b1;
            state_d  = WAIT;
            cnt_d    = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          load_retire = 1'b1;
          state_d     = RUN;
          cnt_d       = '0;
        end else if (cnt_q == CNT_MAX) begin
          load_fault = 1'b1;
          state_d    = RUN;
          cnt_d      = '0;
        end else begin
          wb_stall = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Pipeline register next value: hold while frozen (this is also why a
  // flush during WAIT cannot touch the committed load), otherwise capture EX
  // with flush squashing the incoming instruction.
  always_comb begin
    wb_valid_d  = wb_valid_q;
    wb_rd_d     = wb_rd_q;
    wb_reg_we_d = wb_reg_we_q;
    wb_sel_d    = wb_sel_q;
    wb_alu_d    = wb_alu_q;
    wb_pc_d     = wb_pc_q;
    wb_funct3_d = wb_funct3_q;
    if (!wb_stall) begin
      wb_valid_d  = ex_valid && !flush;
      wb_rd_d     = ex_rd;
      wb_reg_we_d = ex_reg_we;
      wb_sel_d    = ex_wb_sel;
      wb_alu_d    = ex_alu_result;
      wb_pc_d     = ex_pc;
      wb_funct3_d = ex_funct3;
    end
  end

  // Pipeline register flops; reset empties the stage so an in-flight load is
  // abandoned without writing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_reg_we_q <= 1'b0;
      wb_sel_q    <= WB_SEL_ALU;
      wb_alu_q    <= '0;
      wb_pc_q     <= '0;
      wb_funct3_q <= '0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_reg_we_q <= wb_reg_we_d;
      wb_sel_q    <= wb_sel_d;
      wb_alu_q    <= wb_alu_d;
      wb_pc_q     <= wb_pc_d;
      wb_funct3_q <= wb_funct3_d;
    end
  end

  // FSM state and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Writeback bus. Loads only write in their retire cycle; a timed-out load
  // retires silently. PC+4 wraps naturally at XLEN bits.
  always_comb begin
    wb_addr = wb_rd_q;
    is_wb   = wb_is_load ? (load_retire && wb_we) : wb_we;
    case (wb_sel_q)
      WB_SEL_MEM: wb_data = load_data;
      WB_SEL_PC4: wb_data = wb_pc_q + XLEN'(4);
      default:    wb_data = wb_alu_q;
    endcase
`ifndef WB_LOAD_BYPASS_EN
    is_wb_load = is_wb && wb_is_load;
`endif
  end

  // Load-use detection. A freeze already stops upstream, so the bubble
  // request is suppressed while wb_stall is high. Without load bypass, a load
  // still sitting in WB also blocks a dependent ID instruction.
  always_comb begin
    ex_hit = ex_valid && (ex_wb_sel == WB_SEL_MEM) && ex_reg_we &&
             (ex_rd != '0) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) ||
              (id_use_rs2 && (id_rs2 == ex_rd)));
`ifdef WB_LOAD_BYPASS_EN
    lu_stall = ex_hit && !wb_stall;
`else
    lu_stall = (ex_hit ||
                (wb_is_load && wb_we &&
                 ((id_use_rs1 && (id_rs1 == wb_rd_q)) ||
                  (id_use_rs2 && (id_rs2 == wb_rd_q))))) && !wb_stall;
`endif
  end

endmodule

// File: tb/tb_wb_bypass_source.sv
// -----------------------------------------------------------------------------
// tb_wb_bypass_source
//
// Self-checking bench for wb_bypass_source. A behavioural model tracks which
// instruction sits in WB and how many cycles a load has been waiting for
// data; expected outputs are derived from that each cycle. Directed scenarios
// are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_wb_bypass_source;

  localparam int MEM_TIMEOUT = 15;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_reg_we;
  logic [1:0]  ex_wb_sel;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_pc;
  logic [2:0]  ex_funct3;
  logic        flush;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        is_wb;
  logic        wb_stall;
  logic        lu_stall;
  logic        load_fault;
`ifndef WB_LOAD_BYPASS_EN
  logic        is_wb_load;
`endif

  int checkCount = 0;
  int errCount   = 0;

  // Model of the WB slot
  logic        mValid;
  logic        mWe;
  logic [4:0]  mRd;
  logic [1:0]  mSel;
  logic [31:0] mAlu;
  logic [31:0] mPc;
  logic [2:0]  mF3;
  int          mWaitCycles;

  // Expected outputs for the current cycle
  logic        eIsWb;
  logic        eStall;
  logic        eLu;
  logic        eFault;
  logic        eIsWbLoad;
  logic [31:0] eData;

  wb_bypass_source #(
    .XLEN        (32),
    .RA_W        (5),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_reg_we     (ex_reg_we),
    .ex_wb_sel     (ex_wb_sel),
    .ex_alu_result (ex_alu_result),
    .ex_pc         (ex_pc),
    .ex_funct3     (ex_funct3),
    .flush         (flush),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .dmem_rdata    (dmem_rdata),
    .dmem_rvalid   (dmem_rvalid),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .is_wb         (is_wb),
    .wb_stall      (wb_stall),
    .lu_stall      (lu_stall),
    .load_fault    (load_fault)
`ifndef WB_LOAD_BYPASS_EN
    ,
    .is_wb_load    (is_wb_load)
`endif
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check, reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Load result from plain shifting/masking of the returned word
  function automatic logic [31:0] refExtend(input logic [2:0] f3,
                                            input logic [1:0] addr,
                                            input logic [31:0] rdata);
    logic [31:0]       byteVal;
    logic [31:0]       halfVal;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    byteVal = (rdata >> (8 * addr)) & 32'hFF;
    halfVal = (rdata >> (16 * addr[1])) & 32'hFFFF;
    sb = byteVal[7:0];
    sh = halfVal[15:0];
    case (f3)
      3'd0:    return 32'(sb);
      3'd1:    return 32'(sh);
      3'd4:    return byteVal;
      3'd5:    return halfVal;
      default: return rdata;
    endcase
  endfunction

  // Expected outputs from the model WB slot and the current inputs
  task automatic computeExpected();
    logic isLoad;
    logic weEff;
    logic hitEx;
    logic hitWb;
    isLoad = mValid && (mSel == 2'd1);
    weEff  = mValid && mWe && (mRd != 5'd0);
    eIsWb  = 1'b0;
    eStall = 1'b0;
    eFault = 1'b0;
    if (!isLoad)                         eIsWb  = weEff;
    else if (dmem_rvalid)                eIsWb  = weEff;
    else if (mWaitCycles >= MEM_TIMEOUT) eFault = 1'b1;
    else                                 eStall = 1'b1;
    if (mSel == 2'd1)      eData = refExtend(mF3, mAlu[1:0], dmem_rdata);
    else if (mSel == 2'd2) eData = mPc + 32'd4;
    else                   eData = mAlu;
    hitEx = ex_valid && (ex_wb_sel == 2'd1) && ex_reg_we && (ex_rd != 5'd0) &&
            ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    hitWb = isLoad && weEff &&
            ((id_use_rs1 && id_rs1 == mRd) || (id_use_rs2 && id_rs2 == mRd));
`ifdef WB_LOAD_BYPASS_EN
    hitWb = 1'b0;
`endif
    eLu       = (hitEx || hitWb) && !eStall;
    eIsWbLoad = eIsWb && isLoad;
  endtask

  task automatic resetModel();
    mValid = 1'b0; mWe = 1'b0; mRd = '0; mSel = '0;
    mAlu = '0; mPc = '0; mF3 = '0; mWaitCycles = 0;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic we,
                               input logic [1:0] sel, input logic [31:0] alu,
                               input logic [31:0] pc, input logic [2:0] f3,
                               input logic fl, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [31:0] rdata, input logic rvalid);
    ex_valid = v; ex_rd = rd; ex_reg_we = we; ex_wb_sel = sel;
    ex_alu_result = alu; ex_pc = pc; ex_funct3 = f3; flush = fl;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    dmem_rdata = rdata; dmem_rvalid = rvalid;
  endtask

  task automatic applyIdle(input logic [31:0] rdata, input logic rvalid);
    applyStimulus(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'd0, 1'b0,
                  5'd0, 1'b0, 5'd0, 1'b0, rdata, rvalid);
  endtask

  // Compare every output against the model, a little after the inputs settle
  task automatic sampleCycle();
    #1;
    computeExpected();
    checkOutput("is_wb", 32'(is_wb), 32'(eIsWb));
    checkOutput("wb_stall", 32'(wb_stall), 32'(eStall));
    checkOutput("lu_stall", 32'(lu_stall), 32'(eLu));
    checkOutput("load_fault", 32'(load_fault), 32'(eFault));
    if (eIsWb) begin
      checkOutput("wb_addr", 32'(wb_addr), 32'(mRd));
      checkOutput("wb_data", wb_data, eData);
    end
`ifndef WB_LOAD_BYPASS_EN
    checkOutput("is_wb_load", 32'(is_wb_load), 32'(eIsWbLoad));
`endif
  endtask

  // Step the model with the applied inputs, then cross the clock edge
  task automatic advance();
    computeExpected();
    if (eStall) begin
      mWaitCycles++;
    end else begin
      mWaitCycles = 0;
      mValid = ex_valid && !flush;
      mWe = ex_reg_we; mRd = ex_rd; mSel = ex_wb_sel;
      mAlu = ex_alu_result; mPc = ex_pc; mF3 = ex_funct3;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_is_wb"}, 32'(is_wb), 32'd0);
    checkOutput({tag, "_wb_addr"}, 32'(wb_addr), 32'd0);
    checkOutput({tag, "_wb_data"}, wb_data, 32'd0);
    checkOutput({tag, "_wb_stall"}, 32'(wb_stall), 32'd0);
    checkOutput({tag, "_lu_stall"}, 32'(lu_stall), 32'd0);
    checkOutput({tag, "_load_fault"}, 32'(load_fault), 32'd0);
  endtask

  // Main sequence: reset, directed scenarios, then random traffic
  initial begin
    int stallCount;
    int faultCount;
    int faultAt;

    rst_n = 1'b0;
    applyIdle(32'h0, 1'b0);
    resetModel();
    @(negedge clk);
    @(negedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ALU write to rd=5, then the same op to x0
    applyStimulus(1, 5'd5, 1, 2'd0, 32'h1234, 32'h0, 3'd0, 0, 5'd0, 0, 5'd0, 0, 32'h0, 0);
    sampleCycle(); advance();
    applyStimulus(1, 5'd0, 1, 2'd0, 32'h1234, 32'h0, 3'd0, 0, 5'd0, 0, 5'd0, 0, 32'h0, 0);
    sampleCycle();
    checkOutput("alu_is_wb", 32'(is_wb), 32'd1);
    checkOutput("alu_addr", 32'(wb_addr), 32'd5);
    checkOutput("alu_data", wb_data, 32'h1234);
    advance();

    // JAL: PC+4 and its wrap-around
    applyStimulus(1, 5'd1, 1, 2'd2, 32'h0, 32'h100, 3'd0, 0, 5'd0, 0, 5'd0, 0, 32'h0, 0);
    sampleCycle();
    checkOutput("x0_is_wb", 32'(is_wb), 32'd0);
    advance();
    applyStimulus(1, 5'd1, 1, 2'd2, 32'h0, 32'hFFFF_FFFC, 3'd0, 0, 5'd0, 0, 5'd0, 0, 32'h0, 0);
    sampleCycle();
    checkOutput("pc4_data", wb_data, 32'h104);
    advance();

    // Loads with data returned in the WB cycle
    applyStimulus(1, 5'd2, 1, 2'd1, 32'h3, 32'h0, 3'd0, 0, 5'd0, 0, 5'd0, 0, 32'h0, 0);
    sampleCycle();
    checkOutput("pc4_wrap_data", wb_data, 32'h0);
    advance();
    applyStimulus(1, 5'd3, 1, 2'd1, 32'h3, 32'h0, 3'd4, 0, 5'd0, 0, 5'd0, 0, 32'h80FF_FF7F, 1);
    sampleCycle();
    checkOutput("lb_data", wb_data, 32'hFFFF_FF80);
    checkOutput("lb_is_wb", 32'(is_wb), 32'd1);
    advance();
    applyStimulus(1, 5'd4, 1, 2'd1, 32'h2, 32'h0, 3'd1, 0, 5'd0, 0, 5'd0, 0, 32'h80FF_FF7F, 1);
    sampleCycle();
    checkOutput("lbu_data", wb_data, 32'h80);
    advance();

    // Load-use: load to rd=7 in EX, ID reading rs2=7 with and without use
    applyStimulus(1, 5'd7, 1, 2'd1, 32'h0, 32'h0, 3'd2, 0, 5'd0, 0, 5'd7, 1, 32'h80FF_FF7F, 1);
    sampleCycle();
    checkOutput("lh_data", wb_data, 32'hFFFF_80FF);
    checkOutput("lu_hit", 32'(lu_stall), 32'd1);
    applyStimulus(1, 5'd7, 1, 2'd1, 32'h0, 32'h0, 3'd2, 0, 5'd0, 0, 5'd7, 0, 32'h80FF_FF7F, 1);
    sampleCycle();
    checkOutput("lu_nouse", 32'(lu_stall), 32'd0);
    advance();
    applyIdle(32'hCAFE_F00D, 1);
    sampleCycle(); advance();

    // Late load: data three cycles late, flush meanwhile must not matter
    applyStimulus(1, 5'd9, 1, 2'd1, 32'h40, 32'h0, 3'd2, 0, 5'd0, 0, 5'd0, 0, 32'h0, 0);
    sampleCycle(); advance();
    stallCount = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 5'd3, 1, 2'd0, 32'h55, 32'h0, 3'd0, 1, 5'd0, 0, 5'd0, 0, 32'h0, 0);
      sampleCycle();
      if (wb_stall) stallCount++;
      advance();
    end
    applyStimulus(1, 5'd3, 1, 2'd0, 32'h55, 32'h0, 3'd0, 0, 5'd0, 0, 5'd0, 0, 32'hDEAD_BEEF, 1);
    sampleCycle();
    checkOutput("late_stall_cycles", 32'(stallCount), 32'd3);
    checkOutput("late_is_wb", 32'(is_wb), 32'd1);
    checkOutput("late_addr", 32'(wb_addr), 32'd9);
    checkOutput("late_data", wb_data, 32'hDEAD_BEEF);
    checkOutput("late_release", 32'(wb_stall), 32'd0);
    advance();
    applyStimulus(1, 5'd11, 1, 2'd1, 32'h44, 32'h0, 3'd2, 0, 5'd0, 0, 5'd0, 0, 32'h0, 0);
    sampleCycle();
    checkOutput("after_late_data", wb_data, 32'h55);
    advance();
    applyIdle(32'h1234_5678, 1);
    sampleCycle();
    checkOutput("run_again_stall", 32'(wb_stall), 32'd0);
    checkOutput("run_again_data", wb_data, 32'h1234_5678);
    advance();

    // Timeout: data never arrives
    applyStimulus(1, 5'd10, 1, 2'd1, 32'h80, 32'h0, 3'd2, 0, 5'd0, 0, 5'd0, 0, 32'h0, 0);
    sampleCycle(); advance();
    stallCount = 0;
    faultCount = 0;
    faultAt    = -1;
    for (int i = 0; i < 40 && faultAt < 0; i++) begin
      applyIdle(32'h0, 0);
      sampleCycle();
      if (wb_stall) stallCount++;
      if (load_fault) begin
        faultCount++;
        faultAt = i;
        checkOutput("timeout_is_wb", 32'(is_wb), 32'd0);
      end
      advance();
    end
    checkOutput("timeout_stall_cycles", 32'(stallCount), 32'd15);
    checkOutput("timeout_fault_cycle", 32'(faultAt), 32'd15);
    checkOutput("timeout_fault_count", 32'(faultCount), 32'd1);
    applyIdle(32'h0, 0);
    sampleCycle(); advance();

    // Reset in the middle of WAIT abandons the load
    applyStimulus(1, 5'd12, 1, 2'd1, 32'h0, 32'h0, 3'd2, 0, 5'd0, 0, 5'd0, 0, 32'h0, 0);
    sampleCycle(); advance();
    for (int i = 0; i < 3; i++) begin
      applyIdle(32'h0, 0);
      sampleCycle(); advance();
    end
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midwait_reset");
    resetModel();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyIdle(32'hABCD_0123, 1);
    sampleCycle();
    checkOutput("abandoned_is_wb", 32'(is_wb), 32'd0);
    advance();

    // Randomized traffic with small register numbers to provoke hazards
    for (int n = 0; n < 1000; n++) begin
      logic [1:0]  sel;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          k;
      sel  = 2'($urandom_range(0, 2));
      k    = $urandom_range(0, 4);
      f3   = (k == 0) ? 3'd0 : (k == 1) ? 3'd1 : (k == 2) ? 3'd2 : (k == 3) ? 3'd4 : 3'd5;
      addr = $urandom;
      if (f3 == 3'd1 || f3 == 3'd5) addr[0] = 1'b0;
      if (f3 == 3'd2) addr[1:0] = 2'b00;
      applyStimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                    $urandom_range(0, 3) != 0, sel, addr, $urandom, f3,
                    $urandom_range(0, 7) == 0,
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom_range(0, 2) == 0);
      sampleCycle();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, errCount);
    $finish;
  end

endmodule
